// File: rtl/ram_access_ctrl_pkg.sv
// ram_access_ctrl_pkg: size/state encodings and alignment rule shared by the load/store unit.
package ram_access_ctrl_pkg;
  typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10, SIZE_X = 2'b11} size_e;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_FAULT} state_e;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return size == SIZE_X || (size == SIZE_H && a[0]) || (size == SIZE_W && a != 2'b00);
  endfunction
endpackage

// File: rtl/ram_access_ctrl_lane_align.sv
// ram_access_ctrl_lane_align: extracts/extends load lanes and merges store lanes into a RAM word.
module ram_access_ctrl_lane_align
  import ram_access_ctrl_pkg::*;
(
  input  logic [31:0] ram_word_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] rdata_o,
  output logic [31:0] wword_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = ram_word_i[{addr_i, 3'b000} +: 8];
    h = ram_word_i[{addr_i[1], 4'b0000} +: 16];
    rdata_o = size_i == SIZE_B ? {{24{b[7] & ~unsigned_i}}, b} :
              size_i == SIZE_H ? {{16{h[15] & ~unsigned_i}}, h} : ram_word_i;
    wword_o = size_i == SIZE_W ? wdata_i : old_word_i;
    if (size_i == SIZE_B) wword_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
    if (size_i == SIZE_H) wword_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
  end
endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: load/store unit driving a byte-enable-less word RAM, sub-word stores via read-modify-write.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int RAM_AW = 8
) (
  input  logic              iRAC_CLK,
  input  logic              iRAC_RST,
  input  logic              iRAC_REQ,
  input  logic              iRAC_WE,
  input  logic [1:0]        iRAC_SIZE,
  input  logic              iRAC_UNSIGNED,
  input  logic [31:0]       iRAC_ADDR,
  input  logic [31:0]       iRAC_WDATA,
  output logic [31:0]       oRAC_RDATA,
  output logic              oRAC_READY,
  output logic              oRAC_BUSY,
  output logic              oRAC_MISALIGN,
  output logic [31:0]       oRAM_DATA,
  input  logic [31:0]       iRAM_DATA,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic              oRAM_WR,
  output logic [RAM_AW-1:0] oRAM_ADDR
);
  state_e            state_q;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [RAM_AW+1:0] addr_q;
  logic [31:0]       wdata_q, rword_q, rdata_q, ext, wword;
  logic              unused_addr;
  assign unused_addr = ^iRAC_ADDR[31:RAM_AW+2];
  ram_access_ctrl_lane_align u_align (
    .ram_word_i (iRAM_DATA),
    .old_word_i (rword_q),
    .wdata_i    (wdata_q),
    .addr_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .rdata_o    (ext),
    .wword_o    (wword)
  );
  always_ff @(posedge iRAC_CLK or negedge iRAC_RST) begin
    if (!iRAC_RST) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (iRAC_REQ) begin
          we_q    <= iRAC_WE;
          uns_q   <= iRAC_UNSIGNED;
          size_q  <= iRAC_SIZE;
          addr_q  <= iRAC_ADDR[RAM_AW+1:0];
          wdata_q <= iRAC_WDATA;
          state_q <= misaligned(iRAC_SIZE, iRAC_ADDR[1:0]) ? S_FAULT :
                     (iRAC_WE && iRAC_SIZE == SIZE_W) ? S_WR : S_RD;
        end
        S_RD: begin
          rword_q <= iRAM_DATA;
          if (!we_q) rdata_q <= ext;
          state_q <= we_q ? S_WR : S_DONE;
        end
        S_WR:    state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  // All strobes decode straight from the state register so they drop with reset
  assign oRAM_CE       = state_q == S_RD || state_q == S_WR;
  assign oRAM_RD       = state_q == S_RD;
  assign oRAM_WR       = state_q == S_WR;
  assign oRAM_ADDR     = oRAM_CE ? addr_q[RAM_AW+1:2] : '0;
  assign oRAM_DATA     = oRAM_WR ? wword : '0;
  assign oRAC_READY    = state_q == S_DONE || state_q == S_FAULT;
  assign oRAC_MISALIGN = state_q == S_FAULT;
  assign oRAC_BUSY     = state_q != S_IDLE;
  assign oRAC_RDATA    = rdata_q;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed table, corner sequences and random accesses against a word-array reference model.
module tb_ram_access_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, ram_wdata, ram_rdata;
  logic        ready, busy, mis, ram_ce, ram_rd, ram_wr;
  logic [7:0]  ram_addr;
  logic [31:0] mem [256];
  logic [31:0] mdl [256];
  logic [31:0] exp_rd = '0;
  int checks = 0, failures = 0;

  ram_access_ctrl dut (
    .iRAC_CLK(clk), .iRAC_RST(rst_n), .iRAC_REQ(req), .iRAC_WE(we), .iRAC_SIZE(size),
    .iRAC_UNSIGNED(uns), .iRAC_ADDR(addr), .iRAC_WDATA(wdata), .oRAC_RDATA(rdata),
    .oRAC_READY(ready), .oRAC_BUSY(busy), .oRAC_MISALIGN(mis), .oRAM_DATA(ram_wdata),
    .iRAM_DATA(ram_rdata), .oRAM_CE(ram_ce), .oRAM_RD(ram_rd), .oRAM_WR(ram_wr), .oRAM_ADDR(ram_addr)
  );

  always #5 clk = ~clk;
  assign ram_rdata = (ram_ce && ram_rd) ? mem[ram_addr] : 32'h0;
  always @(posedge clk) if (ram_ce && ram_wr) mem[ram_addr] <= ram_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req_v);
    end
  endtask

  function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [31:0] a, input logic [1:0] s, input bit u);
    longint v;
    if (s == 2'd0) begin
      v = (w >> (8 * a[1:0])) & 255;
      if (!u && v >= 128) v = v - 256;
    end else if (s == 2'd1) begin
      v = (w >> (16 * a[1])) & 65535;
      if (!u && v >= 32768) v = v - 65536;
    end else v = w;
    return v[31:0];
  endfunction

  function automatic logic [31:0] st_val(input logic [31:0] w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [31:0] m;
    if (s == 2'd2) return d;
    m = (s == 2'd0) ? (32'hFF << (8 * a[1:0])) : (32'hFFFF << (16 * a[1]));
    return (w & ~m) | ((d << ((s == 2'd0) ? 8 * a[1:0] : 16 * a[1])) & m);
  endfunction

  task automatic access(input bit w, input logic [1:0] s, input bit u, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd_o, output int lat, output bit mis_o);
    bit   bad;
    int   idx, nrd, nwr, elat;
    bad = s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
    idx = int'(a[9:2]);
    nrd = 0;
    nwr = 0;
    @(negedge clk);
    req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (1) begin
      nrd += int'(ram_ce && ram_rd);
      nwr += int'(ram_ce && ram_wr);
      if (ready || lat >= 10) break;
      @(negedge clk);
      lat++;
    end
    chk("ready_seen", {31'b0, ready}, 32'd1);
    rd_o = rdata;
    mis_o = mis;
    if (!bad && w) mdl[idx] = st_val(mdl[idx], a, s, d);
    if (!bad && !w) exp_rd = ld_val(mdl[idx], a, s, u);
    elat = bad ? 1 : (w && s != 2'd2) ? 3 : 2;
    chk("latency", lat, elat);
    chk("misalign", {31'b0, mis}, {31'b0, bad});
    chk("rdata", rdata, exp_rd);
    chk("rd_strobes", nrd, (!bad && !(w && s == 2'd2)) ? 1 : 0);
    chk("wr_strobes", nwr, (!bad && w) ? 1 : 0);
    chk("mem_word", mem[idx], mdl[idx]);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr, wdata, rdata;
    int          lat;
    bit          mis;
  } vec_t;
  vec_t tv [11];

  initial begin
    logic [31:0] r, sa, sd;
    int lat, k, cyc, last, nce, nrd, nwr, nrdy, bad_words;
    bit m;
    tv[0]  = '{0, 2'd2, 0, 32'h000, 32'h0,        32'h8899AABB, 2, 0};
    tv[1]  = '{0, 2'd0, 0, 32'h002, 32'h0,        32'hFFFFFF99, 2, 0};
    tv[2]  = '{0, 2'd0, 1, 32'h002, 32'h0,        32'h00000099, 2, 0};
    tv[3]  = '{0, 2'd1, 0, 32'h002, 32'h0,        32'hFFFF8899, 2, 0};
    tv[4]  = '{1, 2'd0, 0, 32'h001, 32'h123456CC, 32'hFFFF8899, 3, 0};
    tv[5]  = '{0, 2'd2, 0, 32'h000, 32'h0,        32'h8899CCBB, 2, 0};
    tv[6]  = '{1, 2'd1, 0, 32'h003, 32'h5555AAAA, 32'h8899CCBB, 1, 1};
    tv[7]  = '{0, 2'd3, 0, 32'h000, 32'h0,        32'h8899CCBB, 1, 1};
    tv[8]  = '{1, 2'd2, 0, 32'h404, 32'hDEADBEEF, 32'h8899CCBB, 2, 0};
    tv[9]  = '{0, 2'd2, 0, 32'h004, 32'h0,        32'hDEADBEEF, 2, 0};
    tv[10] = '{0, 2'd0, 0, 32'hFFFFFC07, 32'h0,   32'hFFFFFFDE, 2, 0};
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h8899AABB;
    for (int i = 0; i < 256; i++) mdl[i] = mem[i];
    #12;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ctl", {26'b0, ready, busy, mis, ram_ce, ram_rd, ram_wr}, 32'h0);
    chk("rst_ram_bus", {ram_addr, ram_wdata[23:0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      access(tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata, r, lat, m);
      chk($sformatf("tv%0d_rdata", i), r, tv[i].rdata);
      chk($sformatf("tv%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("tv%0d_mis", i), {31'b0, m}, {31'b0, tv[i].mis});
    end

    // REQ held high, alternating aligned LW/SW: one access every 3 cycles
    @(negedge clk);
    req = 1'b1; size = 2'd2; uns = 1'b0; we = 1'b0;
    addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00}; wdata = $urandom;
    k = 0; cyc = 0; last = -1; nce = 0;
    while (k < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      nce += int'(ram_ce);
      if (ready) begin
        if (we) mdl[addr[9:2]] = wdata;
        else begin
          exp_rd = mdl[addr[9:2]];
          chk("b2b_rdata", rdata, exp_rd);
        end
        if (last >= 0) chk("b2b_gap", cyc - last, 3);
        last = cyc;
        k++;
        we = k[0];
        addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        wdata = $urandom;
        if (k == 6) req = 1'b0;
      end
    end
    req = 1'b0;
    chk("b2b_count", k, 6);
    chk("b2b_strobes", nce, 6);

    // REQ toggled during a read-modify-write must not start anything new
    @(negedge clk);
    sa = 32'h0000_0021; sd = $urandom;
    req = 1'b1; we = 1'b1; size = 2'd0; uns = 1'b0; addr = sa; wdata = sd;
    nrd = 0; nwr = 0; nrdy = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      nrd += int'(ram_ce && ram_rd);
      nwr += int'(ram_ce && ram_wr);
      nrdy += int'(ready);
      if (c == 3) chk("tog_ready_cycle", {31'b0, ready}, 32'd1);
      if (c > 3) chk("tog_idle", {30'b0, busy, ram_ce}, 32'd0);
      req = (c < 3) ? ~req : 1'b0;
      addr = $urandom; we = 1'($urandom); wdata = $urandom;
    end
    mdl[sa[9:2]] = st_val(mdl[sa[9:2]], sa, 2'd0, sd);
    chk("tog_rd", nrd, 1);
    chk("tog_wr", nwr, 1);
    chk("tog_ready", nrdy, 1);
    chk("tog_mem", mem[sa[9:2]], mdl[sa[9:2]]);

    // Reset while an RMW sits in RD: outputs clear at once and the write never happens
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd1; addr = 32'h0000_000A; wdata = 32'h0000_7E57;
    @(negedge clk);
    req = 1'b0;
    chk("rmw_in_rd", {31'b0, ram_rd}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", {26'b0, ready, busy, mis, ram_ce, ram_rd, ram_wr}, 32'h0);
    chk("arst_bus", {ram_addr, 24'b0} | ram_wdata, 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    exp_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_write", mem[2], mdl[2]);
    access(0, 2'd1, 1, 32'h0000_000A, 32'h0, r, lat, m);

    for (int i = 0; i < 200; i++)
      access(1'($urandom), ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
             1'($urandom), $urandom, $urandom, r, lat, m);

    bad_words = 0;
    for (int i = 0; i < 256; i++) bad_words += int'(mem[i] !== mdl[i]);
    chk("mem_all", bad_words, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
